// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths, controller state encoding and port-select type for the register file write path.
package regfile_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 3;
  typedef enum logic {CLR = 1'b0, RUN = 1'b1} state_t;
  typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin arbiter; the pointer only advances when both ports contend.
module rr_arb2
  import regfile_pkg::*;
(
  input  logic  i_a_req,
  input  logic  i_b_req,
  input  port_t i_ptr,
  output logic  o_gnt,
  output port_t o_sel,
  output port_t o_ptr_nxt
);
  logic w_both;
  assign w_both    = i_a_req && i_b_req;
  assign o_gnt     = i_a_req || i_b_req;
  assign o_sel     = w_both ? i_ptr : (i_a_req ? PORT_A : PORT_B);
  assign o_ptr_nxt = w_both ? (i_ptr == PORT_A ? PORT_B : PORT_A) : i_ptr;
endmodule

// File: rtl/regfile_write_ctrl.sv
// regfile_write_ctrl: shares the register file write port between two requesters and runs a zero-clear
// sequence after reset or on command.
module regfile_write_ctrl
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NREGS  = 2 ** ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_clear,
  input  logic              i_a_req,
  input  logic [ADDR_W-1:0] i_a_addr,
  input  logic [DATA_W-1:0] i_a_data,
  output logic              o_a_gnt,
  input  logic              i_b_req,
  input  logic [ADDR_W-1:0] i_b_addr,
  input  logic [DATA_W-1:0] i_b_data,
  output logic              o_b_gnt,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data,
  output logic              o_busy
);
  state_t            r_state;
  port_t             r_ptr;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_wr_en, r_a_gnt, r_b_gnt;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic              w_gnt;
  port_t             w_sel, w_ptr_nxt;
  rr_arb2 u_arb (
    .i_a_req  (i_a_req),
    .i_b_req  (i_b_req),
    .i_ptr    (r_ptr),
    .o_gnt    (w_gnt),
    .o_sel    (w_sel),
    .o_ptr_nxt(w_ptr_nxt)
  );
  // CLEAR is only looked at in RUN, so a clear in progress never restarts.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state   <= CLR;
      r_cnt     <= '0;
      r_ptr     <= PORT_A;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_a_gnt   <= 1'b0;
      r_b_gnt   <= 1'b0;
    end else begin
      r_a_gnt <= 1'b0;
      r_b_gnt <= 1'b0;
      if (r_state == CLR) begin
        r_wr_en   <= 1'b1;
        r_wr_addr <= r_cnt;
        r_wr_data <= '0;
        r_cnt     <= r_cnt + 1'b1;
        if (r_cnt == ADDR_W'(NREGS - 1)) begin
          r_state <= RUN;
          r_cnt   <= '0;
        end
      end else if (i_clear) begin
        r_state <= CLR;
        r_wr_en <= 1'b0;
      end else begin
        r_wr_en <= w_gnt;
        if (w_gnt) begin
          r_wr_addr <= (w_sel == PORT_B) ? i_b_addr : i_a_addr;
          r_wr_data <= (w_sel == PORT_B) ? i_b_data : i_a_data;
          r_a_gnt   <= (w_sel == PORT_A);
          r_b_gnt   <= (w_sel == PORT_B);
          r_ptr     <= w_ptr_nxt;
        end
      end
    end
  end
  assign o_wr_en   = r_wr_en;
  assign o_wr_addr = r_wr_addr;
  assign o_wr_data = r_wr_data;
  assign o_a_gnt   = r_a_gnt;
  assign o_b_gnt   = r_b_gnt;
  assign o_busy    = (r_state == CLR);
endmodule

// File: doc/regfile_write_ctrl.md
# regfile_write_ctrl

Write-port controller for the 8×8 register file. It shares the register file's single write port between two requesters: port A (ALU writeback) and port B (load/immediate path). After reset, and on command, it runs a sequenced clear that writes zero to every register, one per cycle. Its registered outputs drive the register file's WRITE, INADDRESS and IN inputs directly.

## Interface
- DATA_W, 8: data width; matches the register width.
- ADDR_W, 3: register address width.
- NREGS, 2**ADDR_W: number of registers cleared by the clear sequence.

- CLK  in  1  clock; all state changes on the rising edge.
- RESET  in  1  synchronous, active-low reset; sampled on the CLK rising edge.
- CLEAR  in  1  request to re-run the zero-clear sequence; level, sampled each edge.
- A_REQ  in  1  port A write request.
- A_ADDR  in  ADDR_W  port A target register.
- A_DATA  in  DATA_W  port A write data.
- A_GNT  out  1  one-cycle pulse; port A request accepted.
- B_REQ, B_ADDR, B_DATA, B_GNT: same as port A, for port B.
- WR_EN  out  1  to register file WRITE.
- WR_ADDR  out  ADDR_W  to register file INADDRESS.
- WR_DATA  out  DATA_W  to register file IN.
- BUSY  out  1  high while the clear sequence is in progress.

## Operation
- There are two states: CLR and RUN.
- Reset (RESET low at an edge):
  - state=CLR, clear counter=0, round-robin pointer=A.
  - WR_EN=0, WR_ADDR=0, WR_DATA=0, A_GNT=0, B_GNT=0, BUSY=1.
  - All outputs stay at these values for as long as RESET is low.
- CLR state:
  - On each edge, register WR_EN=1, WR_ADDR=counter, WR_DATA=0, then increment the counter.
  - After the edge that issues address NREGS-1, go to RUN and reset the counter to 0.
  - No grants are issued in CLR. Requests stay pending; requesters keep REQ, ADDR and DATA stable until granted.
  - CLEAR is ignored while in CLR. The sequence does not restart.
- RUN state, evaluated on each edge:
  - CLEAR=1: go to CLR. No grant is issued at this edge, even if requests are present. CLEAR has priority over requests.
  - Only one REQ high: grant it.
  - Both REQ high: grant the port named by the pointer, then point the pointer at the other port. The pointer changes only on a contested grant.
  - On a grant: register WR_EN=1, WR_ADDR and WR_DATA from the granted port, and a one-cycle pulse on that port's GNT.
  - No grant: WR_EN=0. WR_ADDR and WR_DATA hold their previous values.
- Requester protocol:
  - REQ, ADDR and DATA must stay stable until GNT is observed.
  - If REQ is still high on the edge that ends the GNT cycle, it is a new request.
  - Changing ADDR or DATA while REQ is high and ungranted is illegal. Behaviour in that case is undefined.
- Both ports targeting the same address is legal. The writes are serialized in grant order, so the later grant wins.
- BUSY=1 exactly during the cycles in which state=CLR.

## Timing
- Grant latency: a request present at edge N, in RUN with no conflict, produces GNT and WR_EN high during cycle N→N+1.
- The register file captures the write at edge N+1.
- Throughput: one write per cycle. With both ports requesting continuously, grants alternate A, B, A, B.
- Clear duration: exactly NREGS cycles (8 by default) with WR_EN=1. The first RUN grant can come from the edge that ends the last clear cycle.
- After RESET rises, the first clear write (address 0) is issued at the first edge that samples RESET high.
- Reset in mid-operation:
  - Any edge with RESET low aborts the current clear or grant. Outputs return to their reset values.
  - The clear restarts from address 0 after RESET is released.
- CLEAR asserted at the same edge as RESET low: reset dominates.

## Structure
- Shared package regfile_pkg holds:
  - DATA_W and ADDR_W defaults.
  - The state encoding (CLR=0, RUN=1).
  - A port-select enum (PORT_A, PORT_B) used for the pointer.
- A single optional sub-module, rr_arb2: a 2-input round-robin arbiter that takes the two REQ signals and returns the grant select and the next pointer value.
- The datapath muxing and the clear counter stay in the top module.

## Test plan
- Reset then release: verify WR_EN=1 for 8 consecutive cycles with WR_ADDR 0..7 and WR_DATA=0x00, BUSY=1 throughout, then BUSY=0. The register file reads back all zeros.
- Single request in RUN: A_REQ with A_ADDR=3, A_DATA=0x5A → A_GNT pulses one cycle later together with WR_EN=1, WR_ADDR=3, WR_DATA=0x5A; register 3 reads 0x5A.
- Contention: A and B request continuously (A: reg 1 / 0x11, B: reg 2 / 0x22) for 4 grants → grant order A, B, A, B; exactly one GNT per cycle.
- Same-address conflict: A writes 0x0F and B writes 0xF0 to reg 5 with the pointer at A → writes occur in the order A then B; register 5 finally reads 0xF0.
- CLEAR in RUN with A_REQ pending → no grant at that edge, 8 clear cycles with BUSY=1, then A_GNT is issued and its write lands after the clear.
- RESET pulled low during clear cycle 4 → outputs return to their reset values; after release the clear restarts at address 0 and runs the full 8 cycles.
